// File: rtl/rr_stream_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_stream_arbiter_pkg : shared widths and index helpers            |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rr_stream_arbiter_pkg;

  localparam int bcnt_w = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Circular increment that does not assume a power-of-two modulus.
  function automatic int wrap_inc(input int k, input int n);
    return (k + 1 >= n) ? 0 : k + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_stream_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_stream_arbiter_if : requester bundle plus shared output port    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface rr_stream_arbiter_if #(
  parameter int width_p = 8,
  parameter int req_p   = 4
);
  import rr_stream_arbiter_pkg::*;

  localparam int id_w = clog2(req_p);

  logic [req_p*width_p-1:0] req_data_i;
  logic [req_p-1:0]         req_valid_i;
  logic [req_p-1:0]         req_ready_o;
  logic                     grant_valid_o;
  logic [width_p-1:0]       grant_data_o;
  logic [id_w-1:0]          grant_id_o;
  logic                     grant_ready_i;

  modport slave (
    input  req_data_i, req_valid_i, grant_ready_i,
    output req_ready_o, grant_valid_o, grant_data_o, grant_id_o
  );

  modport master (
    output req_data_i, req_valid_i, grant_ready_i,
    input  req_ready_o, grant_valid_o, grant_data_o, grant_id_o
  );

endinterface
`default_nettype wire

// File: rtl/rr_stream_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick : first valid requester in circular order from prio_ptr    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_pick
  import rr_stream_arbiter_pkg::*;
#(
  parameter int req_p = 4,
  localparam int id_w = clog2(req_p)
) (
  input  logic [req_p-1:0] req_valid,
  input  logic [id_w-1:0]  prio_ptr,
  output logic [req_p-1:0] grant,
  output logic [id_w-1:0]  winner
);

  localparam int sum_w = id_w + 1;

  logic [sum_w-1:0] idx;
  logic             found;

  always_comb begin
    grant  = '0;
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < req_p; i++) begin
      // Explicit subtract keeps the wrap correct for non-power-of-two req_p.
      idx = {1'b0, prio_ptr} + sum_w'(i);
      if (idx >= sum_w'(req_p)) idx = idx - sum_w'(req_p);
      if (!found && req_valid[idx[id_w-1:0]]) begin
        found                = 1'b1;
        grant[idx[id_w-1:0]] = 1'b1;
        winner               = idx[id_w-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_stream_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_stream_arbiter : round-robin N:1 stream arbiter, burst-capable  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rr_stream_arbiter
  import rr_stream_arbiter_pkg::*;
#(
  parameter int width_p = 8,
  parameter int req_p   = 4,
  parameter int burst_p = 1
) (
  input  logic                clk_i,
  input  logic                reset_ni,
  rr_stream_arbiter_if.slave  bus
);

  localparam int id_w = clog2(req_p);

  logic                grant_valid_q, grant_valid_d;
  logic [width_p-1:0]  grant_data_q,  grant_data_d;
  logic [id_w-1:0]     grant_id_q,    grant_id_d;
  logic [id_w-1:0]     prio_ptr_q,    prio_ptr_d;
  logic [id_w-1:0]     owner_q,       owner_d;
  logic [bcnt_w-1:0]   bcnt_q,        bcnt_d;

  logic [req_p-1:0]    pick_grant;
  logic [id_w-1:0]     pick_idx;
  logic                free;
  logic                xfer;
  logic                same_owner;
  logic                burst_room;

  rr_pick #(.req_p(req_p)) u_pick (
    .req_valid (bus.req_valid_i),
    .prio_ptr  (prio_ptr_q),
    .grant     (pick_grant),
    .winner    (pick_idx)
  );

  assign free            = ~grant_valid_q | bus.grant_ready_i;
  assign xfer            = reset_ni & free & (|bus.req_valid_i);
  assign bus.req_ready_o = (reset_ni & free) ? pick_grant : '0;

  assign same_owner = (pick_idx == owner_q);
  // One spare bit so bcnt+1 cannot overflow when burst_p is 255.
  assign burst_room = ({1'b0, bcnt_q} + (bcnt_w+1)'(1)) < (bcnt_w+1)'(burst_p);

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_data_d  = grant_data_q;
    grant_id_d    = grant_id_q;
    prio_ptr_d    = prio_ptr_q;
    owner_d       = owner_q;
    bcnt_d        = bcnt_q;
    if (xfer) begin
      grant_valid_d = 1'b1;
      grant_data_d  = bus.req_data_i[pick_idx*width_p +: width_p];
      grant_id_d    = pick_idx;
      owner_d       = pick_idx;
      if (same_owner && burst_room) begin
        prio_ptr_d = pick_idx;
        bcnt_d     = bcnt_q + bcnt_w'(1);
      end else if (!same_owner && (burst_p > 1)) begin
        prio_ptr_d = pick_idx;
        bcnt_d     = bcnt_w'(1);
      end else begin
        prio_ptr_d = id_w'(wrap_inc(int'(pick_idx), req_p));
        bcnt_d     = '0;
      end
    end else if (free) begin
      grant_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      grant_valid_q <= 1'b0;
      grant_data_q  <= '0;
      grant_id_q    <= '0;
      prio_ptr_q    <= '0;
      owner_q       <= '0;
      bcnt_q        <= '0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_data_q  <= grant_data_d;
      grant_id_q    <= grant_id_d;
      prio_ptr_q    <= prio_ptr_d;
      owner_q       <= owner_d;
      bcnt_q        <= bcnt_d;
    end
  end

  assign bus.grant_valid_o = grant_valid_q;
  assign bus.grant_data_o  = grant_data_q;
  assign bus.grant_id_o    = grant_id_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rr_stream_arbiter : scoreboard bench, burst_p=1 and burst_p=3   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rr_stream_arbiter;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_stream_arbiter_if #(.width_p(W), .req_p(N)) bus1 ();
  rr_stream_arbiter_if #(.width_p(W), .req_p(N)) bus3 ();

  rr_stream_arbiter #(.width_p(W), .req_p(N), .burst_p(1)) dut1 (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus1.slave));
  rr_stream_arbiter #(.width_p(W), .req_p(N), .burst_p(3)) dut3 (
    .clk_i(clk), .reset_ni(rst_n), .bus(bus3.slave));

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic test_reset();
    bus1.req_valid_i   = 4'hF;
    bus1.req_data_i    = 32'h44332211;
    bus1.grant_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus1.grant_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus1.grant_valid_o);
    end
    n_checks++;
    if (bus1.grant_data_o !== 8'h00 || bus1.grant_id_o !== 2'd0) begin
      n_fail++; $display("FAIL reset_data_id: got data %h id %0d expected 00/0", bus1.grant_data_o, bus1.grant_id_o);
    end
    n_checks++;
    if (bus1.req_ready_o !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 0000", bus1.req_ready_o);
    end
    rst_n = 1'b1;
    bus1.req_valid_i = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    int         seq[5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_rdy;
    exp_t       e;
    for (int c = 0; c < 5; c++) begin
      for (int k = 0; k < N; k++) bus1.req_data_i[k*W +: W] = 8'(c*16 + k);
      bus1.req_valid_i   = 4'hF;
      bus1.grant_ready_i = 1'b1;
      exp_q.push_back('{id: 2'(seq[c]), data: 8'(c*16 + seq[c])});
      exp_rdy = 4'(1 << seq[c]);
      #1;
      n_checks++;
      if (bus1.req_ready_o !== exp_rdy) begin
        n_fail++; $display("FAIL rot_ready c=%0d: got %b expected %b", c, bus1.req_ready_o, exp_rdy);
      end
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (bus1.grant_valid_o !== 1'b1 || bus1.grant_id_o !== e.id || bus1.grant_data_o !== e.data) begin
        n_fail++; $display("FAIL rot_out c=%0d: got v%b id %0d data %h expected v1 id %0d data %h",
                           c, bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o, e.id, e.data);
      end
    end
    bus1.req_valid_i = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_burst();
    int   seq[7] = '{1, 1, 1, 2, 2, 2, 1};
    exp_t e;
    bus3.grant_ready_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus3.req_data_i    = '0;
      bus3.req_data_i[1*W +: W] = 8'(8'h50 + c);
      bus3.req_data_i[2*W +: W] = 8'(8'hA0 + c);
      bus3.req_valid_i   = 4'b0110;
      exp_q.push_back('{id: 2'(seq[c]), data: (seq[c] == 1) ? 8'(8'h50 + c) : 8'(8'hA0 + c)});
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (bus3.grant_valid_o !== 1'b1 || bus3.grant_id_o !== e.id || bus3.grant_data_o !== e.data) begin
        n_fail++; $display("FAIL burst_out c=%0d: got v%b id %0d data %h expected v1 id %0d data %h",
                           c, bus3.grant_valid_o, bus3.grant_id_o, bus3.grant_data_o, e.id, e.data);
      end
    end
    bus3.req_valid_i = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    bus1.req_data_i = '0;
    bus1.req_data_i[2*W +: W] = 8'hA5;
    bus1.req_valid_i   = 4'b0100;
    bus1.grant_ready_i = 1'b1;
    exp_q.push_back('{id: 2'd2, data: 8'hA5});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (bus1.grant_valid_o !== 1'b1 || bus1.grant_id_o !== e.id || bus1.grant_data_o !== e.data) begin
      n_fail++; $display("FAIL bp_first: got v%b id %0d data %h expected v1 id 2 data a5",
                         bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o);
    end
    bus1.req_data_i[2*W +: W] = 8'h3C;
    bus1.grant_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (bus1.req_ready_o !== 4'b0000) begin
        n_fail++; $display("FAIL bp_ready i=%0d: got %b expected 0000", i, bus1.req_ready_o);
      end
      @(negedge clk);
      n_checks++;
      if (bus1.grant_valid_o !== 1'b1 || bus1.grant_id_o !== 2'd2 || bus1.grant_data_o !== 8'hA5) begin
        n_fail++; $display("FAIL bp_hold i=%0d: got v%b id %0d data %h expected v1 id 2 data a5",
                           i, bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o);
      end
    end
    bus1.grant_ready_i = 1'b1;
    exp_q.push_back('{id: 2'd2, data: 8'h3C});
    #1;
    n_checks++;
    if (bus1.req_ready_o !== 4'b0100) begin
      n_fail++; $display("FAIL bp_release_ready: got %b expected 0100", bus1.req_ready_o);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (bus1.grant_valid_o !== 1'b1 || bus1.grant_id_o !== e.id || bus1.grant_data_o !== e.data) begin
      n_fail++; $display("FAIL bp_next: got v%b id %0d data %h expected v1 id 2 data 3c",
                         bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o);
    end
    bus1.req_valid_i = 4'h0;
    @(negedge clk);
    n_checks++;
    if (bus1.grant_valid_o !== 1'b0 || bus1.grant_id_o !== 2'd2 || bus1.grant_data_o !== 8'h3C) begin
      n_fail++; $display("FAIL idle_hold: got v%b id %0d data %h expected v0 id 2 data 3c",
                         bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    bus1.req_data_i = '0;
    bus1.req_data_i[3*W +: W] = 8'h77;
    bus1.req_valid_i   = 4'b1000;
    bus1.grant_ready_i = 1'b1;
    exp_q.push_back('{id: 2'd3, data: 8'h77});
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (bus1.grant_valid_o !== 1'b1 || bus1.grant_id_o !== e.id || bus1.grant_data_o !== e.data) begin
      n_fail++; $display("FAIL wrap_id3: got v%b id %0d data %h expected v1 id 3 data 77",
                         bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o);
    end
    bus1.req_data_i[0*W +: W] = 8'h11;
    bus1.req_data_i[3*W +: W] = 8'h88;
    bus1.req_valid_i = 4'b1001;
    exp_q.push_back('{id: 2'd0, data: 8'h11});
    #1;
    n_checks++;
    if (bus1.req_ready_o !== 4'b0001) begin
      n_fail++; $display("FAIL wrap_ready: got %b expected 0001", bus1.req_ready_o);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (bus1.grant_valid_o !== 1'b1 || bus1.grant_id_o !== e.id || bus1.grant_data_o !== e.data) begin
      n_fail++; $display("FAIL wrap_id0: got v%b id %0d data %h expected v1 id 0 data 11",
                         bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o);
    end
    bus1.req_valid_i = 4'h0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    exp_t e;
    for (int k = 0; k < N; k++) bus1.req_data_i[k*W +: W] = 8'(8'hC0 + k);
    bus1.req_valid_i   = 4'hF;
    bus1.grant_ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus1.grant_valid_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got v%b expected v1", bus1.grant_valid_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus1.grant_valid_o !== 1'b0 || bus1.req_ready_o !== 4'b0000 ||
        bus1.grant_data_o !== 8'h00 || bus1.grant_id_o !== 2'd0) begin
      n_fail++; $display("FAIL rstmid_now: got v%b ready %b data %h id %0d expected v0 0000 00 0",
                         bus1.grant_valid_o, bus1.req_ready_o, bus1.grant_data_o, bus1.grant_id_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus1.grant_ready_i = 1'b1;
    n_checks++;
    if (bus1.grant_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_discard: got v%b expected v0", bus1.grant_valid_o);
    end
    exp_q.push_back('{id: 2'd0, data: 8'hC0});
    #1;
    n_checks++;
    if (bus1.req_ready_o !== 4'b0001) begin
      n_fail++; $display("FAIL rstmid_ready: got %b expected 0001", bus1.req_ready_o);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if (bus1.grant_valid_o !== 1'b1 || bus1.grant_id_o !== e.id || bus1.grant_data_o !== e.data) begin
      n_fail++; $display("FAIL rstmid_first: got v%b id %0d data %h expected v1 id 0 data c0",
                         bus1.grant_valid_o, bus1.grant_id_o, bus1.grant_data_o);
    end
    bus1.req_valid_i = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    bus1.req_data_i    = '0;
    bus1.req_valid_i   = '0;
    bus1.grant_ready_i = 1'b0;
    bus3.req_data_i    = '0;
    bus3.req_valid_i   = '0;
    bus3.grant_ready_i = 1'b0;
    test_reset();
    test_rotation();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_stream_arbiter.md
RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

Interface
- REQ-001: width_p, default 8, payload bits per requester.
- REQ-002: req_p, default 4, number of requesters; legal range 2..16.
- REQ-003: burst_p, default 1, maximum consecutive transfers granted to one requester before rotation; legal range 1..255.
- REQ-004: One clock; reset is asynchronous and active-low.
- REQ-005: clk_i  input  1  sole clock; all state updates on its rising edge.
- REQ-006: reset_ni  input  1  asynchronous active-low reset.
- REQ-007: req_data_i  input  req_p*width_p  requester payloads; requester k occupies bits [k*width_p +: width_p].
- REQ-008: req_valid_i  input  req_p  per-requester valid.
- REQ-009: req_ready_o  output  req_p  per-requester ready; one-hot or zero.
- REQ-010: grant_valid_o  output  1  shared-port valid, registered.
- REQ-011: grant_data_o  output  width_p  shared-port payload, registered.
- REQ-012: grant_id_o  output  id_w (clog2(req_p))  index of the requester that sourced grant_data_o, registered.
- REQ-013: grant_ready_i  input  1  shared-resource ready, e.g. a delay buffer's ready.

Function
- REQ-014: Output stage free = ~grant_valid_o | grant_ready_i; no transfer is accepted from any requester when not free.
- REQ-015: When free, the winner is the first requester with req_valid_i=1 in circular order starting at prio_ptr; req_ready_o[winner]=1 combinationally in the same cycle; all other bits are 0.
- REQ-016: Transfer from k occurs when req_valid_i[k] & req_ready_o[k]; on the next edge grant_data_o<=payload k, grant_id_o<=k, grant_valid_o<=1; latency exactly 1 cycle.
- REQ-017: If free and no requester is valid, grant_valid_o<=0 on the next edge; grant_data_o and grant_id_o hold their values.
- REQ-018: While grant_valid_o=1 and grant_ready_i=0, grant_valid_o, grant_data_o and grant_id_o remain stable.
- REQ-019: Full throughput: with grant_ready_i held at 1 and continuous requests, one transfer every cycle.
- REQ-020: Burst counter bcnt (8 bits) counts consecutive transfers from the current owner, which is the last granted requester.
- REQ-021: On a transfer from k: if k equals the owner and bcnt+1 < burst_p, then prio_ptr<=k and bcnt<=bcnt+1; otherwise, if k equals the owner, prio_ptr<=(k+1) mod req_p and bcnt<=0.
- REQ-022: On a transfer from k where k differs from the owner and burst_p > 1, prio_ptr<=k and bcnt<=1; where burst_p = 1, prio_ptr<=(k+1) mod req_p and bcnt<=0.
- REQ-023: A cycle with no transfer leaves prio_ptr and bcnt unchanged. An owner dropping valid forfeits priority only when another requester wins.
- REQ-024: Pointer wrap: (req_p-1)+1 wraps to 0; the modulo is computed without relying on power-of-two req_p.
- REQ-025: No requester starves: any requester held valid is granted within (req_p-1)*burst_p transfers.
- REQ-026: Simultaneous drain and fill (grant_ready_i=1 and a new winner in the same cycle) replaces the output register with no bubble.

Reset
- REQ-027: On reset_ni=0, immediately: grant_valid_o=0, grant_data_o=0, grant_id_o=0, prio_ptr=0, bcnt=0, owner=0.
- REQ-028: req_ready_o is 0 while reset_ni=0. A data word held in the output register when reset asserts mid-operation is discarded and is not re-presented.
- REQ-029: Reset deassertion is synchronized externally; the first transfer can be accepted in the first cycle after release.

Structure
- REQ-030: A shared package holds the id-width function clog2 and the burst counter width constant (8).
- REQ-031: One sub-module, rr_pick: combinational circular priority picker with inputs req_valid and prio_ptr, and outputs one-hot grant and winner index. rr_stream_arbiter instantiates it once.
- REQ-032: All registers live in rr_stream_arbiter. No latches; no combinational path from grant_ready_i to grant_valid_o.

Verification
- REQ-033: Reset mid-burst: reset_ni low while grant_valid_o=1 -> grant_valid_o=0 and req_ready_o=0 immediately; after release, requester 0 has top priority.
- REQ-034: req_p=4, burst_p=1, all valid, grant_ready_i=1 -> grant_id_o sequence 0,1,2,3,0 on consecutive cycles; payloads match.
- REQ-035: burst_p=3, requesters 1 and 2 continuously valid -> ids 1,1,1,2,2,2,1.
- REQ-036: Backpressure: grant_ready_i=0 for 5 cycles with data 0xA5 from id 2 -> output stable and req_ready_o=0 for 5 cycles; the next transfer is accepted in the cycle grant_ready_i returns to 1.
- REQ-037: Only requester 3 valid, pointer at 3 -> grant id 3, then prio_ptr wraps to 0; a subsequent simultaneous request from 0 and 3 grants 0.
